// File: rtl/io_pkg.sv
// ----------------------------------------------------------------------------
// io_pkg
// Shared definitions for the IO-window bus responder:
//   - register offsets inside the 16-word IO window
//   - bit positions of the timer CTRL register
//   - encoding of the access handshake FSM
// ----------------------------------------------------------------------------
package io_pkg;

   // Word offsets inside the IO window (Address[3:0])
   localparam logic [3:0] IO_LED    = 4'h0;
   localparam logic [3:0] IO_SW     = 4'h1;
   localparam logic [3:0] IO_KEY    = 4'h2;
   localparam logic [3:0] IO_CTRL   = 4'h3;
   localparam logic [3:0] IO_LOAD   = 4'h4;
   localparam logic [3:0] IO_COUNT  = 4'h5;
   localparam logic [3:0] IO_STATUS = 4'h6;

   // Timer CTRL register layout
   localparam int CTRL_W      = 3;
   localparam int CTRL_EN     = 0;
   localparam int CTRL_AUTO   = 1;
   localparam int CTRL_IRQ_EN = 2;

   // Access FSM: one request -> one Ready_H pulse -> wait for deselect
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      DONE = 2'd2
   } io_state_t;

endpackage : io_pkg

// File: rtl/io_timer.sv
// ----------------------------------------------------------------------------
// io_timer
// 32-bit (DATA_WIDTH) down-counting timer with one-shot / auto-reload modes
// and a sticky expired flag.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   ctrl_we_i       : one-cycle strobe, wdata_i[2:0] -> CTRL
//   load_we_i       : one-cycle strobe, wdata_i -> LOAD and COUNT
//   status_we_i     : one-cycle strobe, wdata_i[0]=1 clears expired (W1C)
//   wdata_i         : bus write data
//   count_o         : current COUNT
//   load_o          : current LOAD
//   ctrl_o          : current CTRL {irq_en, auto_reload, enable}
//   expired_o       : sticky expired flag
// ----------------------------------------------------------------------------
module io_timer
   import io_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  ctrl_we_i,
   input  logic                  load_we_i,
   input  logic                  status_we_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] count_o,
   output logic [DATA_WIDTH-1:0] load_o,
   output logic [CTRL_W-1:0]     ctrl_o,
   output logic                  expired_o
);

   logic [DATA_WIDTH-1:0] count_q, count_d;
   logic [DATA_WIDTH-1:0] load_q,  load_d;
   logic [CTRL_W-1:0]     ctrl_q,  ctrl_d;
   logic                  expired_q, expired_d;

   // Ordering of assignments encodes priority: later assignments win.
   //   W1C clear < hardware set of expired
   //   hardware enable clear < CTRL write
   //   decrement / reload < LOAD write
   always_comb begin
      count_d   = count_q;
      load_d    = load_q;
      ctrl_d    = ctrl_q;
      expired_d = expired_q;

      if (status_we_i && wdata_i[0]) begin
         expired_d = 1'b0;
      end

      if (ctrl_q[CTRL_EN]) begin
         if (count_q != '0) begin
            count_d = count_q - DATA_WIDTH'(1);
         end else begin
            expired_d = 1'b1;
            if (ctrl_q[CTRL_AUTO]) begin
               count_d = load_q;
            end else begin
               ctrl_d[CTRL_EN] = 1'b0;
            end
         end
      end

      if (ctrl_we_i) begin
         ctrl_d = wdata_i[CTRL_W-1:0];
      end

      if (load_we_i) begin
         load_d  = wdata_i;
         count_d = wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q   <= '0;
         load_q    <= '0;
         ctrl_q    <= '0;
         expired_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         load_q    <= load_d;
         ctrl_q    <= ctrl_d;
         expired_q <= expired_d;
      end
   end

   assign count_o   = count_q;
   assign load_o    = load_q;
   assign ctrl_o    = ctrl_q;
   assign expired_o = expired_q;

endmodule : io_timer

// File: rtl/io_register_responder.sv
// ----------------------------------------------------------------------------
// io_register_responder
// Bus responder for the IO window selected by IO_Select_H. Serves one
// load/store per request with a one-cycle Ready_H pulse and owns the board IO.
//
// Handshake: a request is IO_Select_H & (Read_H | Write_H) seen in IDLE. The
// write is committed and the read data latched on that edge; Ready_H is high
// for exactly the following cycle with Read_Data valid only while Ready_H=1.
// The FSM then waits in DONE until IO_Select_H drops, so a held request is
// served once.
//
// Ports:
//   Clock, Reset_L     : clock, asynchronous active-low reset
//   IO_Select_H        : window select from the address decoder
//   Address[3:0]       : word offset in the window
//   Read_H, Write_H    : load / store request (both = store)
//   Write_Data         : store data
//   Read_Data, Ready_H : load data and access-complete pulse
//   SW, KEY            : asynchronous switch / key pads (KEY active-low)
//   LEDR               : LED register
//   Timer_Irq_H        : level interrupt, expired & irq_en
//   fsm_state_o        : access FSM state (debug observation)
// ----------------------------------------------------------------------------
module io_register_responder
   import io_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_LEDS   = 10,
   parameter int NUM_SW     = 10,
   parameter int NUM_KEYS   = 4
) (
   input  logic                  Clock,
   input  logic                  Reset_L,
   input  logic                  IO_Select_H,
   input  logic [3:0]            Address,
   input  logic                  Read_H,
   input  logic                  Write_H,
   input  logic [DATA_WIDTH-1:0] Write_Data,
   output logic [DATA_WIDTH-1:0] Read_Data,
   output logic                  Ready_H,
   input  logic [NUM_SW-1:0]     SW,
   input  logic [NUM_KEYS-1:0]   KEY,
   output logic [NUM_LEDS-1:0]   LEDR,
   output logic                  Timer_Irq_H,
   output io_state_t             fsm_state_o
);

   // ---------------------------------------------------------------- state
   io_state_t             state_q, state_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [NUM_LEDS-1:0]   led_q,   led_d;
   logic [NUM_SW-1:0]     sw_meta_q, sw_sync_q;
   logic [NUM_KEYS-1:0]   key_meta_q, key_sync_q;

   logic                  req;
   logic                  accept;
   logic                  wr_commit;
   logic [DATA_WIDTH-1:0] rd_mux;

   logic [DATA_WIDTH-1:0] t_count, t_load;
   logic [CTRL_W-1:0]     t_ctrl;
   logic                  t_expired;

   assign req       = IO_Select_H & (Read_H | Write_H);
   assign accept    = (state_q == IDLE) & req;
   assign wr_commit = accept & Write_H;

   // ------------------------------------------------------- synchronisers
   always_ff @(posedge Clock or negedge Reset_L) begin
      if (!Reset_L) begin
         sw_meta_q  <= '0;
         sw_sync_q  <= '0;
         key_meta_q <= '0;
         key_sync_q <= '0;
      end else begin
         sw_meta_q  <= SW;
         sw_sync_q  <= sw_meta_q;
         key_meta_q <= KEY;
         key_sync_q <= key_meta_q;
      end
   end

   // ---------------------------------------------------------------- timer
   io_timer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_timer (
      .clk_i       (Clock),
      .rst_ni      (Reset_L),
      .ctrl_we_i   (wr_commit && (Address == IO_CTRL)),
      .load_we_i   (wr_commit && (Address == IO_LOAD)),
      .status_we_i (wr_commit && (Address == IO_STATUS)),
      .wdata_i     (Write_Data),
      .count_o     (t_count),
      .load_o      (t_load),
      .ctrl_o      (t_ctrl),
      .expired_o   (t_expired)
   );

   assign Timer_Irq_H = t_expired & t_ctrl[CTRL_IRQ_EN];

   // -------------------------------------------------------- read mux
   // Narrow registers are zero-extended; unmapped offsets read 0.
   always_comb begin
      rd_mux = '0;
      case (Address)
         IO_LED:    rd_mux[NUM_LEDS-1:0] = led_q;
         IO_SW:     rd_mux[NUM_SW-1:0]   = sw_sync_q;
         IO_KEY:    rd_mux[NUM_KEYS-1:0] = ~key_sync_q;
         IO_CTRL:   rd_mux[CTRL_W-1:0]   = t_ctrl;
         IO_LOAD:   rd_mux               = t_load;
         IO_COUNT:  rd_mux               = t_count;
         IO_STATUS: rd_mux[0]            = t_expired;
         default:   rd_mux               = '0;
      endcase
   end

   // ------------------------------------------- LED register / read latch
   always_comb begin
      led_d   = led_q;
      rdata_d = rdata_q;
      if (wr_commit && (Address == IO_LED)) begin
         led_d = Write_Data[NUM_LEDS-1:0];
      end
      if (accept) begin
         // A store (including read+write together) returns 0.
         rdata_d = Write_H ? '0 : rd_mux;
      end
   end

   always_ff @(posedge Clock or negedge Reset_L) begin
      if (!Reset_L) begin
         led_q   <= '0;
         rdata_q <= '0;
      end else begin
         led_q   <= led_d;
         rdata_q <= rdata_d;
      end
   end

   assign LEDR = led_q;

   // ------------------------------------------------- FSM: state register
   always_ff @(posedge Clock or negedge Reset_L) begin
      if (!Reset_L) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------- FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req) state_d = ACK;
         ACK:     state_d = DONE;
         DONE:    if (!IO_Select_H) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------- FSM: outputs
   always_comb begin
      Ready_H   = 1'b0;
      Read_Data = '0;
      if (state_q == ACK) begin
         Ready_H   = 1'b1;
         Read_Data = rdata_q;
      end
   end

   assign fsm_state_o = state_q;

endmodule : io_register_responder
